// File: rtl/fp32_accum.sv
// Sequential fp32 accumulator: ALIGN -> ADD -> NORM datapath per element, round-toward-zero,
// no sticky bit, denormals flushed, canonical NaN. Result held in DONE until out_ready_i.
module fp32_accum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic [31:0] in_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic [31:0] out_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;

  state_e      state_q;
  logic [31:0] acc_q, op_q, out_q, spec_val_q;
  logic        last_q, spec_q;
  logic [26:0] ma_q, mb_q;
  logic        sa_q, sb_q, sgn_q;
  logic [7:0]  exp_q;
  logic [27:0] sum_q;

  // unpack + align (ALIGN state)
  logic        sa, sb;
  logic [7:0]  ea, eb, diff, exp_d;
  logic [22:0] fa, fb;
  logic        a_nan, b_nan, a_inf, b_inf, spec_d;
  logic [31:0] spec_val_d;
  logic [26:0] ma_raw, mb_raw, ma_d, mb_d;

  assign {sa, ea, fa} = acc_q;
  assign {sb, eb, fb} = op_q;

  always_comb begin
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    ma_raw = (ea == 8'd0) ? 27'd0 : {1'b1, fa, 3'b000};
    mb_raw = (eb == 8'd0) ? 27'd0 : {1'b1, fb, 3'b000};
    spec_d = 1'b1;
    if (a_nan || b_nan)                 spec_val_d = QNAN;
    else if (a_inf && b_inf && sa != sb) spec_val_d = QNAN;
    else if (a_inf)                     spec_val_d = {sa, 8'hFF, 23'd0};
    else if (b_inf)                     spec_val_d = {sb, 8'hFF, 23'd0};
    else begin
      spec_d     = 1'b0;
      spec_val_d = 32'd0;
    end
    if (ea >= eb) begin
      diff  = ea - eb;
      exp_d = ea;
      ma_d  = ma_raw;
      mb_d  = (diff >= 8'd27) ? 27'd0 : (mb_raw >> diff);
    end else begin
      diff  = eb - ea;
      exp_d = eb;
      mb_d  = mb_raw;
      ma_d  = (diff >= 8'd27) ? 27'd0 : (ma_raw >> diff);
    end
  end

  // signed-magnitude add (ADD state)
  logic [27:0] sum_d;
  logic        sgn_d;

  always_comb begin
    if (sa_q == sb_q) begin
      sum_d = {1'b0, ma_q} + {1'b0, mb_q};
      sgn_d = sa_q;
    end else if (ma_q >= mb_q) begin
      sum_d = {1'b0, ma_q - mb_q};
      sgn_d = (ma_q == mb_q) ? 1'b0 : sa_q;
    end else begin
      sum_d = {1'b0, mb_q - ma_q};
      sgn_d = sb_q;
    end
  end

  // leading-one normalize, truncate, range check (NORM state)
  logic [4:0]  lead, sh;
  logic [27:0] norm;
  logic [9:0]  e_n;
  logic [22:0] m_n;
  logic [31:0] res_d;

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 28; i++)
      if (sum_q[i]) lead = 5'(i);
    sh   = 5'd0;
    norm = sum_q;
    if (sum_q[27]) begin
      m_n = 23'(sum_q >> 4);
      e_n = {2'b00, exp_q} + 10'd1;
    end else begin
      sh   = 5'd26 - lead;
      norm = sum_q << sh;
      m_n  = 23'(norm >> 3);
      e_n  = {2'b00, exp_q} - {5'd0, sh};
    end
    if (spec_q)                     res_d = spec_val_q;
    else if (sum_q == 28'd0)        res_d = {sgn_q, 31'd0};
    else if (e_n[9] || e_n == 10'd0) res_d = {sgn_q, 31'd0};
    else if (e_n >= 10'd255)        res_d = {sgn_q, 8'hFF, 23'd0};
    else                            res_d = {sgn_q, e_n[7:0], m_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= 32'd0;
      op_q       <= 32'd0;
      out_q      <= 32'd0;
      last_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      ma_q       <= 27'd0;
      mb_q       <= 27'd0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      exp_q      <= 8'd0;
      sum_q      <= 28'd0;
      sgn_q      <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      acc_q   <= 32'd0;
      out_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          op_q    <= in_i;
          last_q  <= in_last_i;
          state_q <= ALIGN;
        end
        ALIGN: begin
          ma_q       <= ma_d;
          mb_q       <= mb_d;
          sa_q       <= sa;
          sb_q       <= sb;
          exp_q      <= exp_d;
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
          state_q    <= ADD;
        end
        ADD: begin
          sum_q   <= sum_d;
          sgn_q   <= sgn_d;
          state_q <= NORM;
        end
        NORM: begin
          acc_q <= res_d;
          if (last_q) begin
            out_q   <= res_d;
            state_q <= DONE;
          end else begin
            state_q <= IDLE;
          end
        end
        DONE: if (out_ready_i) begin
          acc_q   <= 32'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_o       = out_q;

endmodule

// File: tb/tb_fp32_accum.sv
// Directed bench for fp32_accum with an integer-arithmetic reference model and a per-cycle output checker.
module tb_fp32_accum;

  logic        clk, rst_n, clr_i, in_valid_i, in_last_i, out_ready_i;
  logic [31:0] in_i;
  logic        in_ready_o, out_valid_o;
  logic [31:0] out_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] expq[$];
  logic [31:0] mout = 32'd0;
  logic [31:0] macc = 32'd0;

  fp32_accum dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .in_i(in_i), .in_valid_i(in_valid_i),
    .in_last_i(in_last_i), .in_ready_o(in_ready_o), .out_o(out_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer sum of the aligned (truncated) operands, then truncate to 24 bits.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, s;
    int   ea, eb, emax, p, re;
    longint ma, mb, v, mag, m;
    logic [7:0] re8;
    logic [31:0] mm;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255 && sa != sb) return 32'h7FC00000;
    if (ea == 255) return {sa, 8'hFF, 23'd0};
    if (eb == 255) return {sb, 8'hFF, 23'd0};
    ma = (ea == 0) ? 0 : (longint'({1'b1, a[22:0]}) * 8);
    mb = (eb == 0) ? 0 : (longint'({1'b1, b[22:0]}) * 8);
    emax = (ea > eb) ? ea : eb;
    ma = ma >> (emax - ea);
    mb = mb >> (emax - eb);
    v = (sa ? -ma : ma) + (sb ? -mb : mb);
    if (v == 0) return (sa && sb) ? 32'h80000000 : 32'h00000000;
    s = (v < 0);
    mag = s ? -v : v;
    p = 0;
    while ((mag >> p) > 1) p++;
    re = emax + p - 26;
    m = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
    if (re >= 255) return {s, 8'hFF, 23'd0};
    if (re <= 0) return {s, 31'd0};
    re8 = 8'(re);
    mm = 32'(m);
    return {s, re8, mm[22:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // per-cycle output check against the scoreboard
  always @(negedge clk) if (rst_n) begin
    checks++;
    if (out_valid_o) begin
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL out_valid_unexpected: out=%08h with no result pending", out_o);
      end else if (out_o !== expq[0]) begin
        errors++;
        $display("FAIL out_value: got %08h expected %08h", out_o, expq[0]);
      end
    end else if (out_o !== mout) begin
      errors++;
      $display("FAIL out_hold: got %08h expected %08h", out_o, mout);
    end
  end

  always @(posedge clk) if (rst_n) begin
    if (clr_i) begin
      expq.delete();
      mout = 32'd0;
      macc = 32'd0;
    end else if (out_valid_o && out_ready_i && expq.size() > 0) begin
      mout = expq.pop_front();
    end
  end

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("in_ready_timeout", {31'd0, in_ready_o}, 32'd1);
      return;
    end
    in_i = d; in_last_i = last; in_valid_i = 1'b1;
    @(posedge clk);
    if (!clr_i) begin
      macc = model_add(macc, d);
      if (last) begin
        expq.push_back(macc);
        macc = 32'd0;
      end
    end
    #1 in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic send_timed(input string nm, input logic [31:0] d, input logic last);
    send(d, last);
    chk({nm, "_rdy_T"}, {31'd0, in_ready_o}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        chk({nm, "_rdy_busy"}, {31'd0, in_ready_o}, 32'd0);
        chk({nm, "_vld_busy"}, {31'd0, out_valid_o}, 32'd0);
      end else if (last) begin
        chk({nm, "_vld_T3"}, {31'd0, out_valid_o}, 32'd1);
      end else begin
        chk({nm, "_rdy_T3"}, {31'd0, in_ready_o}, 32'd1);
      end
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({nm, "_timeout"}, {31'd0, out_valid_o}, 32'd1);
  endtask

  task automatic wait_result(input string nm, input logic [31:0] exp);
    wait_valid(nm);
    chk(nm, out_o, exp);
    out_ready_i = 1'b1;
    @(posedge clk); #1 out_ready_i = 1'b0;
    chk({nm, "_vld_drop"}, {31'd0, out_valid_o}, 32'd0);
  endtask

  task automatic sum2(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    send(a, 1'b0);
    send(b, 1'b1);
    wait_result(nm, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr_i = 1'b0; in_valid_i = 1'b0; in_last_i = 1'b0; in_i = 32'd0; out_ready_i = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out", out_o, 32'd0);
    #11 rst_n = 1'b1;

    // model pins
    chk("model_3p0", model_add(model_add(32'd0, 32'h40000000), 32'h3F800000), 32'h40400000);
    chk("model_6p75", model_add(model_add(32'd0, 32'h410C0000), 32'hC0000000), 32'h40D80000);
    chk("model_trunc", model_add(model_add(32'd0, 32'h4B800000), 32'h3F800000), 32'h4B800000);
    chk("model_ovf", model_add(model_add(32'd0, 32'h7F7FFFFF), 32'h7F7FFFFF), 32'h7F800000);

    // basic sum with exact timing
    send_timed("e1", 32'h40000000, 1'b0);
    send_timed("e2", 32'h3F800000, 1'b1);
    wait_result("basic_3p0", 32'h40400000);

    sum2("mul_6p75", 32'h410C0000, 32'hC0000000, 32'h40D80000);
    sum2("cancel", 32'h3F800000, 32'hBF800000, 32'h00000000);
    sum2("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    sum2("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    sum2("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    sum2("inf_plus_fin", 32'hFF800000, 32'h42C80000, 32'hFF800000);
    sum2("trunc", 32'h4B800000, 32'h3F800000, 32'h4B800000);
    sum2("mixed", 32'h3FC00000, 32'hBE800000, 32'h3FA00000);
    send(32'h00400000, 1'b1);
    wait_result("denorm", 32'h00000000);

    // underflow to -0, then (-0)+(-0)
    send(32'h00800000, 1'b0);
    send(32'h80800001, 1'b0);
    send(32'h80000000, 1'b1);
    wait_result("neg_zero", 32'h80000000);

    // output backpressure
    send(32'h40000000, 1'b0);
    send(32'h3F800000, 1'b1);
    @(negedge clk);
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_out", out_o, 32'h40400000);
      chk("bp_rdy", {31'd0, in_ready_o}, 32'd0);
      in_i = 32'h41200000; in_last_i = 1'b1; in_valid_i = 1'b1;
    end
    @(negedge clk);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1 out_ready_i = 1'b0;
    chk("bp_drop", {31'd0, out_valid_o}, 32'd0);
    send(32'h40000000, 1'b1);
    wait_result("bp_fresh", 32'h40000000);

    // clear during ADD of the second element
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b0);
    @(posedge clk);
    @(negedge clk) clr_i = 1'b1;
    @(posedge clk); #1 clr_i = 1'b0;
    chk("clr_rdy", {31'd0, in_ready_o}, 32'd1);
    chk("clr_out", out_o, 32'd0);
    send(32'h3F800000, 1'b1);
    wait_result("clr_fresh", 32'h3F800000);

    // async reset during NORM
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    expq.delete(); mout = 32'd0; macc = 32'd0;
    #1;
    chk("arst_vld", {31'd0, out_valid_o}, 32'd0);
    chk("arst_rdy", {31'd0, in_ready_o}, 32'd1);
    chk("arst_out", out_o, 32'd0);
    @(negedge clk) #2 rst_n = 1'b1;
    sum2("post_rst", 32'h40400000, 32'h3F800000, 32'h40800000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
